// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, constants and helpers for the per-thread data
//                memory: load-size encoding, data/byte-enable widths and the
//                alignment rule used by the load extractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_DW = 32;    // data word width
    localparam int DMEM_BE = 4;     // byte lanes per word

    // Load access size as carried on rd_size; 2'b11 is reserved/illegal.
    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // True when the access cannot be served from a single naturally aligned
    // lane group: odd halfword, non-zero word offset, or the reserved size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        case (mem_size_e'(size))
            MEM_B:   mis = 1'b0;
            MEM_H:   mis = off[0];
            MEM_W:   mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_align
//  Description : Combinational load extractor. Selects the addressed byte,
//                halfword or word from a 32-bit memory word, applies sign or
//                zero extension, and flags misaligned / illegal accesses.
//                A flagged access returns all-zero data.
//  Ports       : i_word     in  32  raw word (already forwarding-merged)
//                i_off      in  2   byte offset within the word
//                i_size     in  2   00 byte, 01 half, 10 word, 11 illegal
//                i_signed   in  1   1: sign-extend byte/half
//                o_data     out 32  extracted, extended result
//                o_misalign out 1   access misaligned or illegal size
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [DMEM_DW-1:0] i_word,
    input  logic [1:0]         i_off,
    input  logic [1:0]         i_size,
    input  logic               i_signed,
    output logic [DMEM_DW-1:0] o_data,
    output logic               o_misalign
);

    logic [DMEM_DW-1:0] w_shifted;
    logic               w_sign;

    always_comb begin
        // Bring the addressed lane down to bit 0; word accesses are only
        // legal at offset 0, so the shift is a no-op for them.
        w_shifted  = i_word >> {i_off, 3'b000};
        w_sign     = 1'b0;
        o_data     = '0;
        o_misalign = is_misaligned(i_size, i_off);

        if (!o_misalign) begin
            case (mem_size_e'(i_size))
                MEM_B: begin
                    w_sign = i_signed & w_shifted[7];
                    o_data = {{24{w_sign}}, w_shifted[7:0]};
                end
                MEM_H: begin
                    w_sign = i_signed & w_shifted[15];
                    o_data = {{16{w_sign}}, w_shifted[15:0]};
                end
                MEM_W: begin
                    o_data = w_shifted;
                end
                default: begin
                    o_data = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/thread_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : thread_data_memory
//  Description : Per-thread partitioned, byte-addressed data memory for the
//                multithreaded RV32 core (MEM stage). Each hardware thread
//                owns a private DEPTH-word bank. Supports byte-enable stores,
//                same-cycle store-to-load forwarding (write-first), load
//                size/sign extraction, misalignment flagging and an optional
//                output register stage.
//  Ports       : clk, nReset (sync, active low)
//                wr_en/wr_tid/wr_addr/wr_data/wr_be   store port
//                rd_en/rd_tid/rd_addr/rd_size/rd_signed load request
//                rd_data/rd_valid/rd_misalign           load response
//  Latency     : 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), fully pipelined
//  Revision    : 1.0 - initial release
// ============================================================================
module thread_data_memory
    import dmem_pkg::*;
#(
    parameter  int DEPTH   = 128,
    parameter  int THREADS = 4,
    parameter  int OUT_REG = 0,
    localparam int AW      = $clog2(DEPTH) + 2,
    localparam int TW      = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               wr_en,
    input  logic [TW-1:0]      wr_tid,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DMEM_DW-1:0] wr_data,
    input  logic [DMEM_BE-1:0] wr_be,
    input  logic               rd_en,
    input  logic [TW-1:0]      rd_tid,
    input  logic [AW-1:0]      rd_addr,
    input  logic [1:0]         rd_size,
    input  logic               rd_signed,
    output logic [DMEM_DW-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_misalign
);

    // Physical word index {tid, word}: thread banks occupy disjoint ranges.
    localparam int IW    = TW + AW - 2;
    localparam int WORDS = 1 << IW;

    logic [DMEM_DW-1:0] mem_q [WORDS];

    logic [IW-1:0]      w_wr_idx;
    logic [IW-1:0]      w_rd_idx;
    logic [DMEM_DW-1:0] w_rd_word;
    logic [DMEM_DW-1:0] w_ld_data;
    logic               w_ld_mis;
    logic               w_unused_wr_off;

    assign w_wr_idx = {wr_tid, wr_addr[AW-1:2]};
    assign w_rd_idx = {rd_tid, rd_addr[AW-1:2]};

    // Stores are whole-word addressed; the byte offset carries no meaning.
    assign w_unused_wr_off = ^wr_addr[1:0];

    // ------------------------------------------------------------------
    // Storage: one write port with per-lane enables. Contents are not
    // cleared by reset; a store presented during reset is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nReset && wr_en) begin
            for (int i = 0; i < DMEM_BE; i++) begin
                if (wr_be[i]) begin
                    mem_q[w_wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port with write-first forwarding: a same-cycle store to the
    // same thread and word overrides the lanes it enables.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = mem_q[w_rd_idx];
        if (wr_en && (w_wr_idx == w_rd_idx)) begin
            for (int i = 0; i < DMEM_BE; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    dmem_load_align u_align (
        .i_word     (w_rd_word),
        .i_off      (rd_addr[1:0]),
        .i_size     (rd_size),
        .i_signed   (rd_signed),
        .o_data     (w_ld_data),
        .o_misalign (w_ld_mis)
    );

    // ------------------------------------------------------------------
    // First response stage. Data only advances on an accepted load so
    // rd_data holds its last value across idle cycles; the misalign flag
    // is qualified by valid.
    // ------------------------------------------------------------------
    logic [DMEM_DW-1:0] s1_data_d,  s1_data_q;
    logic               s1_valid_d, s1_valid_q;
    logic               s1_mis_d,   s1_mis_q;

    always_comb begin
        s1_valid_d = rd_en;
        s1_mis_d   = rd_en & w_ld_mis;
        s1_data_d  = rd_en ? w_ld_data : s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_mis_q   <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
            s1_mis_q   <= s1_mis_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional second stage for timing closure on the WB path.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DMEM_DW-1:0] out_data_d,  out_data_q;
            logic               out_valid_d, out_valid_q;
            logic               out_mis_d,   out_mis_q;

            always_comb begin
                out_valid_d = s1_valid_q;
                out_mis_d   = s1_valid_q & s1_mis_q;
                out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
            end

            always_ff @(posedge clk) begin
                if (!nReset) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                    out_mis_q   <= 1'b0;
                end else begin
                    out_data_q  <= out_data_d;
                    out_valid_q <= out_valid_d;
                    out_mis_q   <= out_mis_d;
                end
            end

            assign rd_data     = out_data_q;
            assign rd_valid    = out_valid_q;
            assign rd_misalign = out_mis_q;
        end else begin : g_no_out_reg
            assign rd_data     = s1_data_q;
            assign rd_valid    = s1_valid_q;
            assign rd_misalign = s1_mis_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_thread_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_thread_data_memory
//  Description : Scoreboard bench. Two instances (OUT_REG=0 and OUT_REG=1)
//                receive identical stimulus; each has its own expected queue
//                and monitor, so the same vectors exercise both latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_thread_data_memory;

    logic        clk = 1'b0;
    logic        nReset;
    logic        wr_en;
    logic [1:0]  wr_tid;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [1:0]  rd_tid;
    logic [8:0]  rd_addr;
    logic [1:0]  rd_size;
    logic        rd_signed;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        rd_mis0, rd_mis1;

    int n_checks = 0;
    int n_fails  = 0;

    logic [32:0] q0[$];   // {misalign, data} expected from dut0
    logic [32:0] q1[$];   // {misalign, data} expected from dut1

    always #5 clk = ~clk;

    thread_data_memory #(.DEPTH(128), .THREADS(4), .OUT_REG(0)) dut0 (
        .clk(clk), .nReset(nReset),
        .wr_en(wr_en), .wr_tid(wr_tid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_tid(rd_tid), .rd_addr(rd_addr), .rd_size(rd_size), .rd_signed(rd_signed),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_misalign(rd_mis0)
    );

    thread_data_memory #(.DEPTH(128), .THREADS(4), .OUT_REG(1)) dut1 (
        .clk(clk), .nReset(nReset),
        .wr_en(wr_en), .wr_tid(wr_tid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_tid(rd_tid), .rd_addr(rd_addr), .rd_size(rd_size), .rd_signed(rd_signed),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_misalign(rd_mis1)
    );

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rd_valid0 === 1'b1) begin
            logic [32:0] e;
            n_checks++;
            if (q0.size() == 0) begin
                n_fails++;
                $display("FAIL dut0_unexpected_valid: got data=%h mis=%b, required no response", rd_data0, rd_mis0);
            end else begin
                e = q0.pop_front();
                if ({rd_mis0, rd_data0} !== e) begin
                    n_fails++;
                    $display("FAIL dut0_load: got mis=%b data=%h, required mis=%b data=%h",
                             rd_mis0, rd_data0, e[32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid1 === 1'b1) begin
            logic [32:0] e;
            n_checks++;
            if (q1.size() == 0) begin
                n_fails++;
                $display("FAIL dut1_unexpected_valid: got data=%h mis=%b, required no response", rd_data1, rd_mis1);
            end else begin
                e = q1.pop_front();
                if ({rd_mis1, rd_data1} !== e) begin
                    n_fails++;
                    $display("FAIL dut1_load: got mis=%b data=%h, required mis=%b data=%h",
                             rd_mis1, rd_data1, e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 4'h0;
    endtask

    task automatic st(input logic [1:0] tid, input logic [8:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_tid  = tid;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
    endtask

    task automatic ld(input logic [1:0] tid, input logic [8:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] exp, input logic mis,
                      input bit push0, input bit push1);
        rd_en     = 1'b1;
        rd_tid    = tid;
        rd_addr   = addr;
        rd_size   = size;
        rd_signed = sgn;
        if (push0) q0.push_back({mis, exp});
        if (push1) q1.push_back({mis, exp});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nReset = 1'b0; wr_en = 1'b0; wr_tid = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_tid = '0; rd_addr = '0; rd_size = '0; rd_signed = 1'b0;
        drain(2);
        @(negedge clk);
        check("reset_valid0", {31'd0, rd_valid0}, 32'd0);
        check("reset_mis0",   {31'd0, rd_mis0},   32'd0);
        check("reset_data0",  rd_data0, 32'd0);
        check("reset_valid1", {31'd0, rd_valid1}, 32'd0);
        check("reset_mis1",   {31'd0, rd_mis1},   32'd0);
        check("reset_data1",  rd_data1, 32'd0);
        @(posedge clk); #1;
        nReset = 1'b1;

        // 1. basic store/load and latency
        st(2'd0, 9'h010, 32'hDEADBEEF, 4'hF); tick();
        ld(2'd0, 9'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1); tick();
        @(negedge clk);
        check("lat_dut0_first_edge", {31'd0, rd_valid0}, 32'd1);
        check("lat_dut1_first_edge", {31'd0, rd_valid1}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_dut0_second_edge", {31'd0, rd_valid0}, 32'd0);
        check("lat_dut1_second_edge", {31'd0, rd_valid1}, 32'd1);
        @(posedge clk); #1;

        // 2. byte / half extraction on 0x80FF7F01
        st(2'd0, 9'h020, 32'h80FF7F01, 4'hF); tick();
        ld(2'd0, 9'h023, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1, 1); tick();
        ld(2'd0, 9'h023, 2'd0, 1'b0, 32'h00000080, 1'b0, 1, 1); tick();
        ld(2'd0, 9'h022, 2'd1, 1'b1, 32'hFFFF80FF, 1'b0, 1, 1); tick();
        ld(2'd0, 9'h020, 2'd1, 1'b0, 32'h00007F01, 1'b0, 1, 1); tick();
        ld(2'd0, 9'h021, 2'd0, 1'b1, 32'h0000007F, 1'b0, 1, 1); tick();

        // 3. partial store, then forwarding in the same cycle
        st(2'd0, 9'h030, 32'h11223344, 4'hF); tick();
        st(2'd0, 9'h030, 32'hAABBCCDD, 4'b0101); tick();
        ld(2'd0, 9'h030, 2'd2, 1'b0, 32'h11BB33DD, 1'b0, 1, 1); tick();
        st(2'd0, 9'h034, 32'h11223344, 4'hF); tick();
        st(2'd0, 9'h034, 32'hAABBCCDD, 4'b0101);
        ld(2'd0, 9'h034, 2'd2, 1'b0, 32'h11BB33DD, 1'b0, 1, 1); tick();
        // store to another thread's same word must not forward
        st(2'd1, 9'h034, 32'h55555555, 4'hF);
        ld(2'd0, 9'h034, 2'd2, 1'b0, 32'h11BB33DD, 1'b0, 1, 1); tick();

        // 4. thread isolation
        st(2'd1, 9'h008, 32'h00000001, 4'hF); tick();
        st(2'd2, 9'h008, 32'h00000002, 4'hF); tick();
        ld(2'd1, 9'h008, 2'd2, 1'b0, 32'h00000001, 1'b0, 1, 1); tick();
        ld(2'd2, 9'h008, 2'd2, 1'b0, 32'h00000002, 1'b0, 1, 1); tick();
        ld(2'd1, 9'h034, 2'd2, 1'b0, 32'h55555555, 1'b0, 1, 1); tick();

        // 5. misaligned / illegal, then aligned recovery
        ld(2'd0, 9'h012, 2'd2, 1'b0, 32'h0, 1'b1, 1, 1); tick();
        ld(2'd0, 9'h011, 2'd1, 1'b1, 32'h0, 1'b1, 1, 1); tick();
        ld(2'd0, 9'h010, 2'd3, 1'b0, 32'h0, 1'b1, 1, 1); tick();
        ld(2'd0, 9'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1); tick();
        drain(3);
        @(negedge clk);
        check("idle_hold_data0", rd_data0, 32'hDEADBEEF);
        check("idle_hold_data1", rd_data1, 32'hDEADBEEF);
        check("idle_mis0", {31'd0, rd_mis0}, 32'd0);
        check("idle_valid1", {31'd0, rd_valid1}, 32'd0);
        @(posedge clk); #1;

        // 6. reset mid-stream
        st(2'd2, 9'h040, 32'h0A0A0A0A, 4'hF); tick();
        st(2'd2, 9'h044, 32'h0B0B0B0B, 4'hF); tick();
        st(2'd2, 9'h048, 32'h0C0C0C0C, 4'hF); tick();
        st(2'd2, 9'h04C, 32'h12345678, 4'hF); tick();
        drain(3);
        // load A: completes before the reset edge on both instances
        ld(2'd2, 9'h040, 2'd2, 1'b0, 32'h0A0A0A0A, 1'b0, 1, 1); tick();
        // load B: dut0 returns it in time, dut1 still holds it in flight
        ld(2'd2, 9'h044, 2'd2, 1'b0, 32'h0B0B0B0B, 1'b0, 1, 0); tick();
        // reset edge: load C and the store are both dropped
        nReset = 1'b0;
        st(2'd2, 9'h04C, 32'hDEADDEAD, 4'hF);
        ld(2'd2, 9'h048, 2'd2, 1'b0, 32'h0C0C0C0C, 1'b0, 0, 0); tick();
        @(negedge clk);
        check("midreset_data0",  rd_data0, 32'd0);
        check("midreset_data1",  rd_data1, 32'd0);
        check("midreset_valid1", {31'd0, rd_valid1}, 32'd0);
        @(posedge clk); #1;
        nReset = 1'b1;
        // load in the first cycle out of reset is accepted
        ld(2'd2, 9'h04C, 2'd2, 1'b0, 32'h12345678, 1'b0, 1, 1); tick();
        ld(2'd2, 9'h048, 2'd2, 1'b0, 32'h0C0C0C0C, 1'b0, 1, 1); tick();
        drain(4);

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
